muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Takes operands and an M-extension op from decode/forwarding, computes over multiple cycles, returns a 32-bit result.
- A valid/ready handshake stalls the pipeline while the unit is busy.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

Parameters:
- WIDTH, `BIT_WIDTH (32): operand/result width; all behaviour below written for 32.
- CNT_W, $clog2(WIDTH): iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- i_valid  in  1  request strobe; accepted only when o_ready=1.
- i_op  in  3  muldiv_op_e operation select.
- i_a  in  WIDTH  rs1 operand.
- i_b  in  WIDTH  rs2 operand.
- i_flush  in  1  abort in-flight op (branch/jump flush).
- o_ready  out  1  high in IDLE only.
- o_valid  out  1  one-cycle result strobe.
- o_result  out  WIDTH  result; holds last value between strobes.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE, o_ready=1, o_valid=0, o_result=0, counter=0.
  - Reset wins over every other input, including mid-operation; no o_valid for an aborted op.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - i_valid=1 latches op, operand magnitudes, result-sign flag and counter=0.
  - Normal path goes to CALC; special cases go directly to DONE.
- Special cases (no CALC):
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=i_a.
  - Signed overflow (i_a=0x80000000, i_b=0xFFFFFFFF): DIV=0x80000000, REM=0.
- CALC:
  - One radix-2 step per cycle for exactly WIDTH cycles (counter 0..31), then DONE.
  - Multiply: shift-add on magnitudes into a 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle; remainder in a WIDTH+1 register.
- Operand signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed operands are converted to magnitude on accept.
- Result sign correction (applied on entry to DONE):
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
- Result select:
  - MUL = low word.
  - MULH/MULHSU/MULHU = high word.
- DONE: o_valid=1 and o_result updated for exactly one cycle; next state IDLE.
- Latency:
  - Accept edge at cycle T → o_valid high in cycle T+WIDTH+1 (T+33).
  - Special cases → o_valid in cycle T+1.
  - Back-to-back throughput: one op per WIDTH+2 cycles.
- i_valid while o_ready=0 is ignored; upstream holds the request.
- i_flush=1 in CALC or DONE:
  - Next state IDLE, o_valid=0 that cycle, o_result unchanged.
  - i_flush in IDLE with i_valid: request dropped, not accepted.
- o_ready is combinational from state; o_valid and o_result are registered.
- Undefined i_op codes complete as normal CALC with result 0.

Decomposition:
- enum_pkg:
  - muldiv_op_e, 3-bit: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7, matching funct3.
  - muldiv_state_e: IDLE, CALC, DONE.
- param.svh: BIT_WIDTH reused; no new macros.
- Optional sub-module muldiv_core: one combinational iteration step (add/shift or trial-subtract) selected by an is_div flag. FSM, sign handling and handshake stay in muldiv_unit.

Test Plan:
- MUL i_a=7, i_b=0xFFFFFFFD (−3) → o_result=0xFFFFFFEB; o_valid exactly 33 cycles after accept; o_ready=0 throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, o_valid one cycle after accept:
  - DIVU 0x1234/0 → 0xFFFFFFFF.
  - REM 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- i_flush in cycle 10 of a DIV → o_ready=1 next cycle, no o_valid, o_result keeps prior value; a following MUL 3×5 returns 15.
- rst_n=0 in cycle 20 of a MUL → next cycle o_ready=1, o_valid=0, o_result=0; i_valid during busy cycles never alters the in-flight result.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Op encoding follows funct3 so decode can pass it straight through.
package muldiv_unit_pkg;

    localparam int BIT_WIDTH = 32;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Multiply keeps {acc, lo} as the product; divide keeps acc = remainder, lo = dividend/quotient.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum, shifted, trial;

    always_comb begin
        addend  = lo[0] ? opnd : '0;
        sum     = acc + {1'b0, addend};
        shifted = {acc[WIDTH-1:0], lo[WIDTH-1]};
        trial   = shifted - {1'b0, opnd};
        if (is_div) begin
            // a clear top bit means the trial subtract did not borrow
            if (!trial[WIDTH]) begin
                acc_nxt = trial;
                lo_nxt  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted;
                lo_nxt  = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {1'b0, sum[WIDTH:1]};
            lo_nxt  = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitudes in, 32 radix-2 steps, sign fix on the way out.
// Divide-by-zero and signed overflow bypass iteration and complete the next cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = BIT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  muldiv_op_e       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    muldiv_state_e    state, state_n;
    muldiv_op_e       op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0] lo, lo_nxt, opnd;
    logic             neg_q, rneg_q;

    logic             a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, spec_res;

    always_comb begin
        a_sgn    = (i_op != MULHU) && (i_op != DIVU) && (i_op != REMU);
        b_sgn    = a_sgn && (i_op != MULHSU);
        a_neg    = a_sgn & i_a[WIDTH-1];
        b_neg    = b_sgn & i_b[WIDTH-1];
        a_mag    = a_neg ? -i_a : i_a;
        b_mag    = b_neg ? -i_b : i_b;
        is_div   = i_op[2];
        div_zero = is_div && (i_b == '0);
        div_ovf  = ((i_op == DIV) || (i_op == REM)) && (i_a == MIN_NEG) && (&i_b);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero) spec_res = i_op[1] ? i_a : '1;
        else          spec_res = i_op[1] ? '0 : MIN_NEG;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (op_q[2]),
        .acc     (acc),
        .lo      (lo),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .lo_nxt  (lo_nxt)
    );

    // final result is formed from the last step's outputs so DONE needs no extra cycle
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, fin_res;

    always_comb begin
        prod = {acc_nxt[WIDTH-1:0], lo_nxt};
        if (neg_q) prod = -prod;
        quot = neg_q  ? -lo_nxt : lo_nxt;
        rem  = rneg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        case (op_q)
            MUL:                 fin_res = prod[WIDTH-1:0];
            MULH, MULHSU, MULHU: fin_res = prod[2*WIDTH-1:WIDTH];
            DIV, DIVU:           fin_res = quot;
            REM, REMU:           fin_res = rem;
            default:             fin_res = '0;
        endcase
    end

    logic             accept, load_res;
    logic [WIDTH-1:0] res_n;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        load_res = 1'b0;
        res_n    = '0;
        case (state)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    accept = 1'b1;
                    if (div_zero || div_ovf) begin
                        state_n  = DONE;
                        load_res = 1'b1;
                        res_n    = spec_res;
                    end else begin
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (i_flush) begin
                    state_n = IDLE;
                end else if (cnt == LAST) begin
                    state_n  = DONE;
                    load_res = 1'b1;
                    res_n    = fin_res;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= MUL;
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            state   <= state_n;
            o_valid <= load_res;
            if (load_res) o_result <= res_n;
            if (accept) begin
                op_q   <= i_op;
                cnt    <= '0;
                acc    <= '0;
                lo     <= is_div ? a_mag : b_mag;
                opnd   <= is_div ? b_mag : a_mag;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
            end else if (state == CALC) begin
                acc <= acc_nxt;
                lo  <= lo_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_ready = (state == IDLE);

endmodule
